fifo_write_arbiter: RTL and testbench

Shares the write port of the 16-in/8-out frame FIFO (32 bytes, 16 words per frame) between two 16-bit producers.
Grants one producer for a whole frame, then holds off new grants until the FIFO has fully drained.
Tags the draining frame with its source ID for the downstream byte consumer.
Round-robin fairness between frames; no interleaving of producers within a frame.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_arb_rr_pick.sv | 35 +++
 rtl/fifo_write_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants for the frame FIFO write arbiter.
// State encoding, producer IDs and default frame length.
package fifo_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam int FRAME_WORDS_DEFAULT = 16;

   localparam logic SRC_P0 = 1'b0;
   localparam logic SRC_P1 = 1'b1;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational 2-way round-robin picker.
// prio names the requester that wins when both ask at once.
module fifo_arb_rr_pick
   import fifo_arb_pkg::*;
(
   input  logic [1:0] valids,
   input  logic       prio,
   output logic [1:0] grant,
   output logic       grant_id
);

   always_comb begin
      grant_id = SRC_P0;
      grant    = 2'b00;
      unique case (valids)
         2'b01: begin
            grant_id = SRC_P0;
            grant    = 2'b01;
         end
         2'b10: begin
            grant_id = SRC_P1;
            grant    = 2'b10;
         end
         2'b11: begin
            grant_id = prio;
            grant    = prio ? 2'b10 : 2'b01;
         end
         default: begin
            grant_id = SRC_P0;
            grant    = 2'b00;
         end
      endcase
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Frame-granular write arbiter for the 16-in/8-out frame FIFO.
// Per-producer frame counters are built only with FIFO_ARB_STATS_EN.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int FRAME_WORDS = FRAME_WORDS_DEFAULT,
   parameter int CNT_W       = 5,
   parameter int STAT_W      = 8
)
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              p0_valid,
   input  logic [15:0]       p0_data,
   output logic              p0_ready,
   input  logic              p1_valid,
   input  logic [15:0]       p1_data,
   output logic              p1_ready,
   output logic              f_input_valid,
   output logic [15:0]       f_data_in,
   input  logic              f_input_enable,
   input  logic              f_output_valid,
   output logic              frame_src,
   output logic              frame_src_valid,
   output logic              busy,
   output logic [STAT_W-1:0] frame_cnt0,
   output logic [STAT_W-1:0] frame_cnt1
);

   logic [1:0]       state;
   logic             owner;
   logic             prio;
   logic [CNT_W-1:0] word_cnt;

   logic [1:0] pick_grant;
   logic       pick_id;
   logic       in_fill;
   logic       in_drain;
   logic       own_valid;
   logic       xfer;
   logic       last_word;
   logic       drain_done;

   fifo_arb_rr_pick u_pick (
      .valids   ({p1_valid, p0_valid}),
      .prio     (prio),
      .grant    (pick_grant),
      .grant_id (pick_id)
   );

   assign in_fill   = (state == ST_FILL);
   assign in_drain  = (state == ST_DRAIN);
   assign own_valid = (owner == SRC_P1) ? p1_valid : p0_valid;
   assign xfer      = in_fill && own_valid && f_input_enable;
   assign last_word = (word_cnt == CNT_W'(FRAME_WORDS - 1));
   // enable back high with nothing left to emit means the last byte is gone
   assign drain_done = in_drain && f_input_enable && !f_output_valid;

   assign p0_ready = in_fill && (owner == SRC_P0) && f_input_enable;
   assign p1_ready = in_fill && (owner == SRC_P1) && f_input_enable;

   assign f_input_valid = in_fill && own_valid;
   assign f_data_in     = !in_fill ? 16'h0000 :
                          (owner == SRC_P1) ? p1_data : p0_data;

   assign frame_src       = owner;
   assign frame_src_valid = in_fill || in_drain;
   assign busy            = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         owner    <= SRC_P0;
         prio     <= SRC_P0;
         word_cnt <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (f_input_enable && |pick_grant) begin
                  owner <= pick_id;
                  state <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (xfer) begin
                  if (last_word) begin
                     word_cnt <= '0;
                     state    <= ST_DRAIN;
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_done) begin
                  prio  <= ~owner;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [STAT_W-1:0] cnt0;
   logic [STAT_W-1:0] cnt1;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (drain_done) begin
         if (owner == SRC_P1) cnt1 <= cnt1 + 1'b1;
         else                 cnt0 <= cnt0 + 1'b1;
      end
   end

   assign frame_cnt0 = cnt0;
   assign frame_cnt1 = cnt1;
`else
   assign frame_cnt0 = '0;
   assign frame_cnt1 = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter with a behavioural frame FIFO.
// Counter expectations follow FIFO_ARB_STATS_EN.
module tb_fifo_write_arbiter;

   localparam int FW = 16;
`ifdef FIFO_ARB_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   typedef struct packed {logic src; logic [15:0] d;} w_t;
   typedef struct packed {logic src; logic [7:0] b;} b_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic p0_valid = 1'b0;
   logic p1_valid = 1'b0;
   logic [15:0] p0_data = 16'h0;
   logic [15:0] p1_data = 16'h0;
   logic p0_ready, p1_ready, f_input_valid;
   logic [15:0] f_data_in;
   logic f_input_enable, f_output_valid;
   logic frame_src, frame_src_valid, busy;
   logic [7:0] frame_cnt0, frame_cnt1;

   int n_vec = 0;
   int n_err = 0;
   int n_acc = 0;
   int wc = 0;
   int sent0 = 0;
   int sent1 = 0;
   int stall_at0 = -1;
   int stall_len0 = 0;
   bit st0 = 1'b0;
   bit pulse0 = 1'b0;
   bit pulse1 = 1'b0;
   bit acc0 = 1'b0;
   bit acc1 = 1'b0;

   logic [15:0] pq0[$];
   logic [15:0] pq1[$];
   logic [7:0]  bq[$];
   w_t exp_w[$];
   b_t exp_b[$];
   w_t ew;
   b_t eb;

   always #5 clk = ~clk;

   fifo_write_arbiter dut (
      .clk             (clk),
      .rstn            (rstn),
      .p0_valid        (p0_valid),
      .p0_data         (p0_data),
      .p0_ready        (p0_ready),
      .p1_valid        (p1_valid),
      .p1_data         (p1_data),
      .p1_ready        (p1_ready),
      .f_input_valid   (f_input_valid),
      .f_data_in       (f_data_in),
      .f_input_enable  (f_input_enable),
      .f_output_valid  (f_output_valid),
      .frame_src       (frame_src),
      .frame_src_valid (frame_src_valid),
      .busy            (busy),
      .frame_cnt0      (frame_cnt0),
      .frame_cnt1      (frame_cnt1)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   task automatic chk_cnt(int c0, int c1);
      chk("frame_cnt0", 32'(frame_cnt0), 32'(c0 * STATS));
      chk("frame_cnt1", 32'(frame_cnt1), 32'(c1 * STATS));
   endtask

   task automatic feed(bit src, logic [15:0] base);
      for (int i = 0; i < FW; i++) begin
         if (src) pq1.push_back(base + 16'(i));
         else     pq0.push_back(base + 16'(i));
      end
   endtask

   task automatic exp_frame(bit src, logic [15:0] base);
      for (int i = 0; i < FW; i++)
         exp_w.push_back({src, 16'(base + 16'(i))});
   endtask

   task automatic wait_all(string nm);
      int k;
      for (k = 0; k < 2000; k++) begin
         @(negedge clk); #1;
         if (exp_w.size() == 0 && exp_b.size() == 0 && !busy) break;
      end
      chk({nm, "_done"}, 32'(k < 2000), 32'd1);
   endtask

   // 16-in/8-out frame FIFO: fills a whole frame, then drains lo byte first
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         f_input_enable <= 1'b1;
         f_output_valid <= 1'b0;
         wc = 0;
         bq.delete();
      end else if (f_input_enable && f_input_valid) begin
         bq.push_back(f_data_in[7:0]);
         bq.push_back(f_data_in[15:8]);
         if (wc == FW - 1) begin
            wc = 0;
            f_input_enable <= 1'b0;
            f_output_valid <= 1'b1;
         end else begin
            wc++;
         end
      end else if (f_output_valid) begin
         void'(bq.pop_front());
         if (bq.size() == 0) begin
            f_output_valid <= 1'b0;
            f_input_enable <= 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (acc0) begin
         void'(pq0.pop_front());
         sent0++;
      end
      if (sent0 == stall_at0 && stall_len0 > 0) begin
         stall_len0--;
         st0 = 1'b1;
      end else begin
         st0 = 1'b0;
      end
      p0_valid = (pq0.size() > 0 && !st0) || pulse0;
      p0_data  = (pq0.size() > 0) ? pq0[0] : 16'h0;
   end

   always @(posedge clk) begin
      #1;
      if (acc1) begin
         void'(pq1.pop_front());
         sent1++;
      end
      p1_valid = (pq1.size() > 0) || pulse1;
      p1_data  = (pq1.size() > 0) ? pq1[0] : 16'h0;
   end

   always @(negedge clk) begin
      if (!rstn) begin
         acc0 = 1'b0;
         acc1 = 1'b0;
      end else begin
         acc0 = p0_valid && p0_ready;
         acc1 = p1_valid && p1_ready;
         chk("fiv_outside_fill", 32'(f_input_valid && !frame_src_valid), 32'd0);
         if (f_input_valid && f_input_enable) begin
            n_acc++;
            if (exp_w.size() == 0) begin
               chk("extra_word", 32'(f_data_in), 32'hFFFF_FFFF);
            end else begin
               ew = exp_w.pop_front();
               chk("word_data", 32'(f_data_in), 32'(ew.d));
               chk("word_src", 32'(frame_src), 32'(ew.src));
               chk("word_ready", 32'({p1_ready, p0_ready}),
                   ew.src ? 32'd2 : 32'd1);
               exp_b.push_back({ew.src, ew.d[7:0]});
               exp_b.push_back({ew.src, ew.d[15:8]});
            end
         end
         if (f_output_valid) begin
            if (exp_b.size() == 0) begin
               chk("extra_byte", 32'(bq[0]), 32'hFFFF_FFFF);
            end else begin
               eb = exp_b.pop_front();
               chk("byte_data", 32'(bq[0]), 32'(eb.b));
               chk("drain_src", 32'({frame_src_valid, frame_src}),
                   32'({1'b1, eb.src}));
               chk("drain_quiet", 32'({p1_ready, p0_ready, f_input_valid}),
                   32'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int base;

      // reset held with both producers requesting, then four contested frames
      feed(1'b0, 16'hA000);
      feed(1'b0, 16'hA010);
      feed(1'b1, 16'hB000);
      feed(1'b1, 16'hB010);
      exp_frame(1'b0, 16'hA000);
      exp_frame(1'b1, 16'hB000);
      exp_frame(1'b0, 16'hA010);
      exp_frame(1'b1, 16'hB010);
      repeat (3) @(negedge clk);
      #1;
      chk("rst_outs", 32'({p0_ready, p1_ready, f_input_valid, frame_src,
                           frame_src_valid, busy}), 32'd0);
      chk("rst_data", 32'(f_data_in), 32'd0);
      chk_cnt(0, 0);
      rstn = 1'b1;
      @(negedge clk); #1;
      chk("grant0", 32'({busy, frame_src, p0_ready, p1_ready}), 32'b1010);
      chk("grant0_data", 32'(f_data_in), 32'hA000);
      wait_all("alt4");
      chk_cnt(2, 2);

      // lone p1 frame, busy falls one cycle after enable returns
      feed(1'b1, 16'h0100);
      exp_frame(1'b1, 16'h0100);
      for (k = 0; k < 500; k++) begin
         @(negedge clk); #1;
         if (exp_w.size() == 0 && exp_b.size() == 0 && f_input_enable) break;
      end
      chk("lone_p1_done", 32'(k < 500), 32'd1);
      chk("busy_hold", 32'(busy), 32'd1);
      @(negedge clk); #1;
      chk("busy_drop", 32'(busy), 32'd0);
      chk_cnt(2, 3);

      // p0 stalls after word 5 while p1 keeps requesting
      sent0 = 0;
      stall_at0 = 5;
      stall_len0 = 10;
      feed(1'b0, 16'h2000);
      feed(1'b1, 16'h3000);
      exp_frame(1'b0, 16'h2000);
      exp_frame(1'b1, 16'h3000);
      for (k = 0; k < 200; k++) begin
         @(negedge clk); #1;
         if (sent0 == 5) break;
      end
      chk("stall_reached", 32'(k < 200), 32'd1);
      for (int i = 0; i < 8; i++) begin
         chk("stall_hold", 32'({busy, frame_src, p1_ready, f_input_valid}),
             32'b1000);
         @(negedge clk); #1;
      end
      wait_all("stall");
      chk_cnt(3, 4);
      stall_at0 = -1;

      // valid pulses on both producers during a drain are ignored
      feed(1'b0, 16'h6000);
      exp_frame(1'b0, 16'h6000);
      for (k = 0; k < 200; k++) begin
         @(negedge clk); #1;
         if (f_output_valid) break;
      end
      chk("drain_reached", 32'(k < 200), 32'd1);
      pulse0 = 1'b1;
      pulse1 = 1'b1;
      @(negedge clk); #1;
      chk("drain_pulse", 32'({p0_valid, p1_valid, p0_ready, p1_ready,
                              f_input_valid}), 32'b11000);
      repeat (3) @(negedge clk);
      #1;
      pulse0 = 1'b0;
      pulse1 = 1'b0;
      wait_all("pulse");
      chk_cnt(4, 4);

      // reset after word 8 of a frame, then a fresh full frame
      base = n_acc;
      feed(1'b1, 16'h5000);
      exp_frame(1'b1, 16'h5000);
      for (k = 0; k < 200; k++) begin
         @(negedge clk); #1;
         if (n_acc >= base + 8) break;
      end
      chk("mid_reached", 32'(k < 200), 32'd1);
      @(posedge clk); #2;
      rstn = 1'b0;
      #1;
      chk("rst_mid", 32'({p0_ready, p1_ready, f_input_valid, frame_src_valid,
                          busy, frame_src}), 32'd0);
      exp_w.delete();
      exp_b.delete();
      pq1.delete();
      p1_valid = 1'b0;
      p1_data = 16'h0;
      repeat (2) @(negedge clk);
      #1;
      chk_cnt(0, 0);
      rstn = 1'b1;
      feed(1'b1, 16'h5100);
      exp_frame(1'b1, 16'h5100);
      wait_all("after_rst");
      chk_cnt(0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
